neurotransmitter_channel: RTL and testbench
===========================================

// Module: neurotransmitter_channel
// PURPOSE
//   Parametrised next-generation neurotransmitter resource channel: one N-bit level driven by a
//   regulator's inc/dec/fast requests. Adds what the fixed per-transmitter systems lack:
//   - idle decay back toward a resting value
//   - habituation, which halves the inc rate under sustained excitation
//   - a hold/freeze input
//   - parametrised downscaled level and min/max flags
//   Sits between a *_regulator and the emotional-state logic; one instance per transmitter.
// PARAMETERS
//   N            7    width of the resource value
//   LEVEL_BITS   2    width of the downscaled level output (LEVEL_BITS <= N)
//   DEFAULT_VAL  96   reset and resting value
//   SET_VAL      64   value loaded by setval
//   FAST_STEP    3    step size when fast=1 (normal step is 1)
//   DECAY_PERIOD 16   idle cycles per decay step toward DEFAULT_VAL; 0 disables decay
//   HAB_CYCLES   8    consecutive applied-inc cycles before habituation; 0 disables habituation
// PORTS
//   clk          in   1           system clock
//   rst_n        in   1           asynchronous active-low reset
//   inc          in   1           request increase
//   dec          in   1           request decrease
//   fast         in   1           use FAST_STEP instead of 1
//   setval       in   1           load SET_VAL
//   hold         in   1           freeze value and all internal counters
//   value        out  N           current resource value (registered)
//   level        out  LEVEL_BITS  value[N-1 -: LEVEL_BITS]
//   at_max       out  1           value == 2^N-1
//   at_min       out  1           value == 0
//   habituated   out  1           habituation active
// BEHAVIOUR
//   Reset (async, rst_n=0): value=DEFAULT_VAL; decay_cnt=0; streak=0; phase=0; habituated=0.
//     Outputs follow from value.
//   Latency: a request sampled at edge t changes value at edge t; level and flags are
//     combinational from value (no extra cycle).
//   Priority each cycle: setval > hold > (inc,dec).
//   - setval: value<=SET_VAL; decay_cnt, streak and phase cleared.
//   - hold: nothing changes.
//   - inc&dec: no value change; streak<=0; decay_cnt<=0.
//   - inc only:
//     - step s = fast ? FAST_STEP : 1; value <= min(value+s, 2^N-1). Compute in N+1 bits and
//       saturate.
//     - If habituated: apply only when phase=1; phase toggles on every inc-only cycle.
//     - streak <= min(streak+1, HAB_CYCLES); decay_cnt<=0.
//   - dec only: value <= max(value-s, 0), computed with a borrow check. Never throttled.
//     streak<=0; phase<=0; decay_cnt<=0.
//   - Idle (no inc/dec/setval/hold):
//     - streak<=0; phase<=0.
//     - If DECAY_PERIOD>0 and decay_cnt==DECAY_PERIOD-1: value moves 1 toward DEFAULT_VAL
//       (unchanged if equal); decay_cnt<=0.
//     - Otherwise decay_cnt++.
//   - habituated = (HAB_CYCLES>0) && (streak==HAB_CYCLES). Because it derives from registered
//     streak, it is effective from the cycle after the HAB_CYCLES-th applied inc.
//   Saturated inc at max or dec at min: value holds. This still counts as activity
//     (decay_cnt<=0) and still counts toward streak.
//   Reset mid-sequence: everything returns to reset values immediately; no pending state.
// STRUCTURE
//   Shared nt_pkg: nt_op_e enum {OP_IDLE, OP_INC, OP_DEC, OP_CONFLICT, OP_SET, OP_HOLD} and a
//     function sat_add_sub(value, step, dir, N).
//   Sub-module nt_decay_timer: idle counter of width $clog2(DECAY_PERIOD+1), with tick output.
//   Top holds op decode, value register, streak/phase logic and flags.
// TESTING (defaults)
//   Reset released, idle 15 cycles -> value=96, level=3; 16th idle -> still 96 (at rest).
//   setval 1 cycle, then 160 idle -> value 64 then 74 (+1 every 16 cycles); level=2.
//   From 96, inc held 12 cycles -> 104 after edge 8, habituated=1 after edge 8, 106 after
//     edge 12; inc off 1 cycle -> habituated=0.
//   setval then value=126 reached, inc+fast -> 127, at_max=1; further inc -> 127, decay_cnt=0.
//   From 2, dec+fast -> 0, at_min=1; inc&dec together -> 0 unchanged; hold 40 cycles -> no decay.
//   Assert rst_n=0 mid-habituation -> value=96, habituated=0 asynchronously, before next clk edge.

Source files
------------

// File: rtl/nt_pkg.sv
// Shared types and helpers for the neurotransmitter resource channel.
// Holds the request decode enum and the saturating add/subtract used for every value update.
package nt_pkg;

   typedef enum logic [2:0] {
      OP_IDLE,
      OP_INC,
      OP_DEC,
      OP_CONFLICT,
      OP_SET,
      OP_HOLD
   } nt_op_e;

   // dir=1 adds and clamps at 2^n-1; dir=0 subtracts and clamps at 0 (n must be < 32).
   function automatic logic [31:0] sat_add_sub(input logic [31:0] value,
                                               input logic [31:0] step,
                                               input logic        dir,
                                               input int unsigned n);
      logic [31:0] max_val;
      logic [32:0] sum;
      logic [31:0] result;
      max_val = (32'd1 << n) - 32'd1;
      sum     = {1'b0, value} + {1'b0, step};
      if (dir) begin
         result = (sum > {1'b0, max_val}) ? max_val : sum[31:0];
      end else begin
         result = (step > value) ? 32'd0 : (value - step);
      end
      return result;
   endfunction

endpackage

// File: rtl/nt_decay_timer.sv
// Idle-cycle counter that pulses tick once every DECAY_PERIOD idle cycles.
// Activity clears it; cycles that are neither idle nor active (hold) leave it frozen.
module nt_decay_timer #(
   parameter int DECAY_PERIOD = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tick
);
   import nt_pkg::*;

   localparam int CW = (DECAY_PERIOD > 0) ? $clog2(DECAY_PERIOD + 1) : 1;

   logic [CW-1:0] cnt_reg;

   generate
      if (DECAY_PERIOD > 0) begin : g_decay
         assign tick = enable && (cnt_reg == CW'(DECAY_PERIOD - 1));
      end else begin : g_no_decay
         assign tick = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (clear || tick) begin
         cnt_reg <= '0;
      end else if (enable && (DECAY_PERIOD > 0)) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/neurotransmitter_channel.sv
// One transmitter's resource level: inc/dec/fast requests from a regulator, idle decay toward
// rest, habituation that halves the inc rate under sustained excitation, and a freeze input.
module neurotransmitter_channel #(
   parameter int N            = 7,
   parameter int LEVEL_BITS   = 2,
   parameter int DEFAULT_VAL  = 96,
   parameter int SET_VAL      = 64,
   parameter int FAST_STEP    = 3,
   parameter int DECAY_PERIOD = 16,
   parameter int HAB_CYCLES   = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  inc,
   input  logic                  dec,
   input  logic                  fast,
   input  logic                  setval,
   input  logic                  hold,
   output logic [N-1:0]          value,
   output logic [LEVEL_BITS-1:0] level,
   output logic                  at_max,
   output logic                  at_min,
   output logic                  habituated
);
   import nt_pkg::*;

   localparam int SW = (HAB_CYCLES > 0) ? $clog2(HAB_CYCLES + 1) : 1;

   nt_op_e        op;
   logic [N-1:0]  value_reg, value_next;
   logic [SW-1:0] streak_reg, streak_next;
   logic          phase_reg, phase_next;
   logic          decay_tick;
   logic [31:0]   step;
   logic [31:0]   step_res;
   logic [31:0]   decay_res;
   logic          unused_hi_bits;

   always_comb begin
      op = OP_IDLE;
      if (setval)          op = OP_SET;
      else if (hold)       op = OP_HOLD;
      else if (inc && dec) op = OP_CONFLICT;
      else if (inc)        op = OP_INC;
      else if (dec)        op = OP_DEC;
   end

   nt_decay_timer #(
      .DECAY_PERIOD(DECAY_PERIOD)
   ) u_decay_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clear ((op != OP_IDLE) && (op != OP_HOLD)),
      .enable(op == OP_IDLE),
      .tick  (decay_tick)
   );

   assign step      = fast ? 32'(FAST_STEP) : 32'd1;
   assign step_res  = sat_add_sub(32'(value_reg), step, op == OP_INC, N);
   // Decay step is zero once at rest, so the value settles instead of oscillating.
   assign decay_res = sat_add_sub(32'(value_reg),
                                  (32'(value_reg) == 32'(DEFAULT_VAL)) ? 32'd0 : 32'd1,
                                  32'(value_reg) < 32'(DEFAULT_VAL), N);
   assign unused_hi_bits = ^{step_res[31:N], decay_res[31:N]};

   assign habituated = (HAB_CYCLES > 0) && (streak_reg == SW'(HAB_CYCLES));

   always_comb begin
      value_next  = value_reg;
      streak_next = streak_reg;
      phase_next  = phase_reg;
      case (op)
         OP_SET: begin
            value_next  = N'(SET_VAL);
            streak_next = '0;
            phase_next  = 1'b0;
         end
         OP_HOLD: ;
         OP_CONFLICT: streak_next = '0;
         OP_INC: begin
            // Once habituated only every other inc cycle lands.
            if (!habituated || phase_reg) value_next = step_res[N-1:0];
            phase_next = ~phase_reg;
            if (streak_reg != SW'(HAB_CYCLES)) streak_next = streak_reg + 1'b1;
         end
         OP_DEC: begin
            value_next  = step_res[N-1:0];
            streak_next = '0;
            phase_next  = 1'b0;
         end
         OP_IDLE: begin
            streak_next = '0;
            phase_next  = 1'b0;
            if (decay_tick) value_next = decay_res[N-1:0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_reg  <= N'(DEFAULT_VAL);
         streak_reg <= '0;
         phase_reg  <= 1'b0;
      end else begin
         value_reg  <= value_next;
         streak_reg <= streak_next;
         phase_reg  <= phase_next;
      end
   end

   assign value  = value_reg;
   assign level  = value_reg[N-1 -: LEVEL_BITS];
   assign at_max = &value_reg;
   assign at_min = ~|value_reg;

endmodule

// File: tb/tb_neurotransmitter_channel.sv
// Bench for neurotransmitter_channel: a behavioural model feeds a scoreboard every cycle, and a
// table of request runs with hand-derived end values checks the documented scenarios.
module tb_neurotransmitter_channel;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       inc = 1'b0, dec = 1'b0, fast = 1'b0, setval = 1'b0, hold = 1'b0;
   logic [6:0] value;
   logic [1:0] level;
   logic       at_max, at_min, habituated;

   int total = 0;
   int bad = 0;

   typedef struct {
      int v;
      bit h;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic i, d, f, s, h;
      int   n;
      int   ev;
      bit   eh;
   } vec_t;
   vec_t tbl[$];

   // reference model state
   int m_val, m_dcnt, m_streak;
   bit m_phase;

   neurotransmitter_channel dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (inc),
      .dec       (dec),
      .fast      (fast),
      .setval    (setval),
      .hold      (hold),
      .value     (value),
      .level     (level),
      .at_max    (at_max),
      .at_min    (at_min),
      .habituated(habituated)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   task automatic model_reset();
      m_val = 96; m_dcnt = 0; m_streak = 0; m_phase = 0;
   endtask

   task automatic model_step(input logic i, input logic d, input logic f, input logic s,
                             input logic h);
      int st;
      bit hab;
      st  = f ? 3 : 1;
      hab = (m_streak == 8);
      if (s) begin
         m_val = 64; m_dcnt = 0; m_streak = 0; m_phase = 0;
      end else if (h) begin
      end else if (i && d) begin
         m_streak = 0; m_dcnt = 0;
      end else if (i) begin
         if (!hab || m_phase) m_val = (m_val + st > 127) ? 127 : m_val + st;
         m_phase  = !m_phase;
         m_streak = (m_streak < 8) ? m_streak + 1 : 8;
         m_dcnt   = 0;
      end else if (d) begin
         m_val = (m_val < st) ? 0 : m_val - st;
         m_streak = 0; m_phase = 0; m_dcnt = 0;
      end else begin
         m_streak = 0; m_phase = 0;
         if (m_dcnt == 15) begin
            if (m_val < 96) m_val++;
            else if (m_val > 96) m_val--;
            m_dcnt = 0;
         end else begin
            m_dcnt++;
         end
      end
   endtask

   // Drive one request on the falling edge, score it after the next rising edge.
   task automatic run_cycle(input logic i, input logic d, input logic f, input logic s,
                            input logic h);
      exp_t e;
      @(negedge clk);
      inc = i; dec = d; fast = f; setval = s; hold = h;
      model_step(i, d, f, s, h);
      sb.push_back('{v: m_val, h: (m_streak == 8)});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      if (value != 7'(e.v) || habituated != e.h || at_max != (e.v == 127)
          || at_min != (e.v == 0) || level != 2'(e.v >> 5)) begin
         total++;
         bad++;
         $display("FAIL cycle_model: got value=%0d hab=%0d max=%0d min=%0d lvl=%0d required value=%0d hab=%0d",
                  value, habituated, at_max, at_min, level, e.v, e.h);
      end else begin
         total++;
      end
   endtask

   task automatic add_vec(input logic i, input logic d, input logic f, input logic s,
                          input logic h, input int n, input int ev, input bit eh);
      tbl.push_back('{i: i, d: d, f: f, s: s, h: h, n: n, ev: ev, eh: eh});
   endtask

   initial begin
      //       inc dec fst set hld  n    value hab
      add_vec(0, 0, 0, 0, 0, 15,  96, 0);
      add_vec(0, 0, 0, 0, 0, 1,   96, 0);
      add_vec(1, 0, 0, 0, 0, 8,  104, 1);
      add_vec(1, 0, 0, 0, 0, 4,  106, 1);
      add_vec(0, 0, 0, 0, 0, 1,  106, 0);
      add_vec(0, 0, 0, 1, 0, 1,   64, 0);
      add_vec(0, 0, 0, 0, 0, 160, 74, 0);
      add_vec(0, 0, 0, 1, 0, 1,   64, 0);
      add_vec(1, 0, 1, 0, 0, 7,   85, 0);
      add_vec(0, 0, 0, 0, 0, 1,   85, 0);
      add_vec(1, 0, 1, 0, 0, 7,  106, 0);
      add_vec(0, 0, 0, 0, 0, 1,  106, 0);
      add_vec(1, 0, 1, 0, 0, 6,  124, 0);
      add_vec(0, 0, 0, 0, 0, 1,  124, 0);
      add_vec(1, 0, 0, 0, 0, 2,  126, 0);
      add_vec(1, 0, 1, 0, 0, 1,  127, 0);
      add_vec(1, 0, 0, 0, 0, 3,  127, 0);
      add_vec(0, 0, 0, 0, 0, 15, 127, 0);
      add_vec(0, 0, 0, 0, 0, 1,  126, 0);
      add_vec(0, 0, 0, 1, 0, 1,   64, 0);
      add_vec(0, 1, 1, 0, 0, 20,   4, 0);
      add_vec(0, 1, 0, 0, 0, 2,    2, 0);
      add_vec(0, 1, 1, 0, 0, 1,    0, 0);
      add_vec(1, 1, 0, 0, 0, 1,    0, 0);
      add_vec(0, 0, 0, 0, 1, 40,   0, 0);
      add_vec(0, 0, 0, 0, 0, 15,   0, 0);
      add_vec(0, 0, 0, 0, 0, 1,    1, 0);
      add_vec(1, 0, 0, 0, 1, 3,    1, 0);
      add_vec(1, 0, 0, 1, 1, 1,   64, 0);
      add_vec(1, 0, 0, 0, 0, 10,  73, 1);

      model_reset();
      repeat (2) @(negedge clk);
      check("reset_value", int'(value), 96);
      check("reset_level", int'(level), 3);
      check("reset_hab", int'(habituated), 0);
      rst_n = 1'b1;

      foreach (tbl[k]) begin
         for (int c = 0; c < tbl[k].n; c++)
            run_cycle(tbl[k].i, tbl[k].d, tbl[k].f, tbl[k].s, tbl[k].h);
         check($sformatf("vec%0d_value", k), int'(value), tbl[k].ev);
         check($sformatf("vec%0d_hab", k), int'(habituated), int'(tbl[k].eh));
         check($sformatf("vec%0d_level", k), int'(level), tbl[k].ev >> 5);
         check($sformatf("vec%0d_at_max", k), int'(at_max), int'(tbl[k].ev == 127));
         check($sformatf("vec%0d_at_min", k), int'(at_min), int'(tbl[k].ev == 0));
      end

      // Asynchronous reset mid-habituation, checked before the next rising edge.
      @(negedge clk);
      inc = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_value", int'(value), 96);
      check("async_rst_hab", int'(habituated), 0);
      check("async_rst_level", int'(level), 3);
      inc = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      run_cycle(1, 0, 0, 0, 0);
      check("post_rst_inc", int'(value), 97);
      check("post_rst_hab", int'(habituated), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
